lpif_rx_quarter_slave_align: RTL and testbench

// - Slave-side receive alignment checker for the LPIF x8 asym2 link; decoder counterpart of the master TX auto-sync marker/strobe insertion.
// - Monitors the extracted RX strobe and marker userbits and confirms the master's periodic strobe and persistent marker pattern.
// - Declares rx_online_delay only after stable lock; drops it on sustained error.
// - Sits between the slave concat block (bit extraction) and the slave upstream user interface.

---
 rtl/lpif_rx_align_pkg.sv | 24 ++
 rtl/ll_sat_counter.sv | 33 +++
 rtl/lpif_rx_quarter_slave_align.sv | 176 +++++++++++++++++
 tb/tb_lpif_rx_quarter_slave_align.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lpif_rx_align_pkg.sv
// Shared types and constants for the LPIF slave-side RX alignment checker.
//   align_state_e : alignment FSM states, encoded as reported in the status word
//   STS_*         : bit offsets of the fields inside rx_align_status
package lpif_rx_align_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        HUNT   = 3'd2,
        CHECK  = 3'd3,
        LOCKED = 3'd4
    } align_state_e;

    localparam int unsigned STS_STATE_LSB  = 0;
    localparam int unsigned STS_STATE_W    = 3;
    localparam int unsigned STS_LOCKED_BIT = 3;
    localparam int unsigned STS_MRK_BIT    = 4;
    localparam int unsigned STS_GOOD_LSB   = 8;
    localparam int unsigned STS_LOSS_LSB   = 12;
    localparam int unsigned STS_CNT4_W     = 4;
    localparam int unsigned STS_ERR_LSB    = 16;
    localparam int unsigned STS_ERR_W      = 16;

endpackage

// File: rtl/ll_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : clear; an increment in the same cycle still counts (result 1)
//   inc_i  : increment request, ignored once the counter is all ones
//   cnt_o  : current count
module ll_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= inc_i ? ONE : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lpif_rx_quarter_slave_align.sv
// Slave-side RX alignment checker for the LPIF x8 asym2 link. Watches the extracted strobe
// and marker userbits, locks after LOCK_COUNT clean strobe periods and raises rx_online_delay,
// drops it again after LOSS_COUNT consecutive error cycles.
//   clk_wr          : clock
//   rst_wr          : synchronous active-high reset
//   rx_online       : PHY/channel alignment done; low forces IDLE
//   delay_x_value   : word-alignment settle time in clocks, sampled in IDLE
//   rx_stb_userbit  : extracted strobe bit
//   rx_mrk_userbit  : extracted marker bits, one per quarter-rate word
//   clr_err         : clears the error counter and the marker-error sticky bit
//   rx_online_delay : aligned indication to upstream logic
//   rx_align_status : debug status {err_cnt, loss_cnt, good_cnt, 3'b0, mrk_sticky, locked, state}
module lpif_rx_quarter_slave_align
    import lpif_rx_align_pkg::*;
#(
    parameter int unsigned              MARKER_WIDTH = 4,
    parameter logic [MARKER_WIDTH-1:0]  MRK_EXPECT   = 4'b1000,
    parameter int unsigned              STB_INTERVAL = 8,
    parameter int unsigned              LOCK_COUNT   = 4,
    parameter int unsigned              LOSS_COUNT   = 2
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr,
    input  logic                    rx_online,
    input  logic [15:0]             delay_x_value,
    input  logic                    rx_stb_userbit,
    input  logic [MARKER_WIDTH-1:0] rx_mrk_userbit,
    input  logic                    clr_err,
    output logic                    rx_online_delay,
    output logic [31:0]             rx_align_status
);

    localparam logic [7:0] PER_LAST = 8'(STB_INTERVAL - 1);
    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

    align_state_e state_q;
    logic [15:0]  dly_cnt_q;
    logic [7:0]   per_cnt_q;
    logic [3:0]   good_cnt_q;
    logic [3:0]   loss_cnt_q;
    logic         online_dly_q;
    logic         mrk_sticky_q;
    logic [15:0]  err_cnt;

    logic stb_due, early_err, miss_err, mrk_err, checking, err_cycle, mrk_err_cycle;
    logic [7:0] per_next;
    logic [3:0] good_inc, loss_inc;

    always_comb begin
        stb_due       = (per_cnt_q == PER_LAST);
        early_err     = rx_stb_userbit && !stb_due;
        miss_err      = !rx_stb_userbit && stb_due;
        mrk_err       = (rx_mrk_userbit != MRK_EXPECT);
        // Errors are only meaningful while tracking the period and while the channel is up;
        // a falling rx_online takes priority and must leave err_cnt untouched.
        checking      = rx_online && ((state_q == CHECK) || (state_q == LOCKED));
        err_cycle     = checking && (early_err || miss_err || mrk_err);
        mrk_err_cycle = checking && mrk_err;
        per_next      = stb_due ? 8'd0 : per_cnt_q + 8'd1;
        good_inc      = good_cnt_q + 4'd1;
        loss_inc      = loss_cnt_q + 4'd1;
    end

    ll_sat_counter #(
        .WIDTH (16)
    ) u_err_cnt (
        .clk_i (clk_wr),
        .rst_i (rst_wr),
        .clr_i (clr_err),
        .inc_i (err_cycle),
        .cnt_o (err_cnt)
    );

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            state_q      <= IDLE;
            dly_cnt_q    <= '0;
            per_cnt_q    <= '0;
            good_cnt_q   <= '0;
            loss_cnt_q   <= '0;
            online_dly_q <= 1'b0;
            mrk_sticky_q <= 1'b0;
        end else begin
            mrk_sticky_q <= (mrk_sticky_q && !clr_err) || mrk_err_cycle;

            if (!rx_online) begin
                state_q      <= IDLE;
                dly_cnt_q    <= '0;
                per_cnt_q    <= '0;
                good_cnt_q   <= '0;
                loss_cnt_q   <= '0;
                online_dly_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q   <= WAIT;
                        dly_cnt_q <= delay_x_value;
                    end
                    WAIT: begin
                        // Leave as the count reaches 0, so a delay of N spends N clocks here
                        // and a delay of 0 still passes through WAIT for one clock.
                        if (dly_cnt_q <= 16'd1) begin
                            state_q   <= HUNT;
                            dly_cnt_q <= '0;
                        end else begin
                            dly_cnt_q <= dly_cnt_q - 16'd1;
                        end
                    end
                    HUNT: begin
                        if (rx_stb_userbit) begin
                            per_cnt_q  <= '0;
                            good_cnt_q <= 4'd1;
                            loss_cnt_q <= '0;
                            // The hunted strobe is the first good one; one may already be enough.
                            if (LOCK_CNT == 4'd1) begin
                                state_q      <= LOCKED;
                                online_dly_q <= 1'b1;
                            end else begin
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        per_cnt_q <= per_next;
                        if (err_cycle) begin
                            state_q    <= HUNT;
                            per_cnt_q  <= '0;
                            good_cnt_q <= '0;
                        end else if (rx_stb_userbit) begin
                            good_cnt_q <= good_inc;
                            if (good_inc == LOCK_CNT) begin
                                state_q      <= LOCKED;
                                online_dly_q <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        per_cnt_q <= per_next;
                        if (err_cycle) begin
                            if (loss_inc == LOSS_CNT) begin
                                state_q      <= HUNT;
                                per_cnt_q    <= '0;
                                good_cnt_q   <= '0;
                                loss_cnt_q   <= '0;
                                online_dly_q <= 1'b0;
                            end else begin
                                loss_cnt_q <= loss_inc;
                            end
                        end else begin
                            loss_cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q      <= IDLE;
                        online_dly_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Status is a pure function of flops, so no input-to-output combinational path exists.
    always_comb begin
        rx_align_status                                 = '0;
        rx_align_status[STS_STATE_LSB +: STS_STATE_W]   = state_q;
        rx_align_status[STS_LOCKED_BIT]                 = online_dly_q;
        rx_align_status[STS_MRK_BIT]                    = mrk_sticky_q;
        rx_align_status[STS_GOOD_LSB +: STS_CNT4_W]     = good_cnt_q;
        rx_align_status[STS_LOSS_LSB +: STS_CNT4_W]     = loss_cnt_q;
        rx_align_status[STS_ERR_LSB +: STS_ERR_W]       = err_cnt;
    end

    assign rx_online_delay = online_dly_q;

endmodule

// File: tb/tb_lpif_rx_quarter_slave_align.sv
module tb_lpif_rx_quarter_slave_align;

    logic        clk_wr = 1'b0;
    logic        rst_wr;

    // Main instance, default parameters
    logic        rx_online, stb, clr;
    logic [15:0] dly;
    logic [3:0]  mrk;
    logic        od;
    logic [31:0] status;

    // Saturation instance: short period, lock on first strobe, long loss window
    logic        rx_online2, stb2, clr2;
    logic [15:0] dly2;
    logic [3:0]  mrk2;
    logic        od2;
    logic [31:0] status2;

    int checks = 0;
    int failures = 0;

    always #5 clk_wr = ~clk_wr;

    lpif_rx_quarter_slave_align dut (
        .clk_wr          (clk_wr),
        .rst_wr          (rst_wr),
        .rx_online       (rx_online),
        .delay_x_value   (dly),
        .rx_stb_userbit  (stb),
        .rx_mrk_userbit  (mrk),
        .clr_err         (clr),
        .rx_online_delay (od),
        .rx_align_status (status)
    );

    lpif_rx_quarter_slave_align #(
        .STB_INTERVAL (2),
        .LOCK_COUNT   (1),
        .LOSS_COUNT   (15)
    ) dut_sat (
        .clk_wr          (clk_wr),
        .rst_wr          (rst_wr),
        .rx_online       (rx_online2),
        .delay_x_value   (dly2),
        .rx_stb_userbit  (stb2),
        .rx_mrk_userbit  (mrk2),
        .clr_err         (clr2),
        .rx_online_delay (od2),
        .rx_align_status (status2)
    );

    typedef struct {
        logic        online;
        logic [15:0] dly;
        logic        stb;
        logic [3:0]  mrk;
        logic        clr;
        int          n;      // clocks to hold these inputs before checking
        logic [2:0]  st;
        logic [3:0]  good;
        logic [3:0]  loss;
        logic [15:0] err;
        logic        sticky;
        logic        od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic on, input logic [15:0] d, input logic s,
                                input logic [3:0] m, input logic c, input int n,
                                input logic [2:0] st, input logic [3:0] g, input logic [3:0] l,
                                input logic [15:0] e, input logic sk, input logic o);
        vec_t v;
        v.online = on; v.dly = d; v.stb = s; v.mrk = m; v.clr = c; v.n = n;
        v.st = st; v.good = g; v.loss = l; v.err = e; v.sticky = sk; v.od = o;
        return v;
    endfunction

    // Expected status word: {err, loss, good, 3'b0, sticky, locked, state}
    function automatic logic [31:0] exp_status(input logic [2:0] s, input logic lk,
                                               input logic sk, input logic [3:0] g,
                                               input logic [3:0] l, input logic [15:0] e);
        return {e, l, g, 3'b000, sk, lk, s};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    initial begin
        // States: 0 IDLE, 1 WAIT, 2 HUNT, 3 CHECK, 4 LOCKED
        // Lock with delay 5; marker junk in HUNT must be ignored
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 4, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 1, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 4'h3, 0, 3, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 7, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 3, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 7, 3, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 3, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 7, 3, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 4, 4, 0, 0, 0, 1));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 7, 4, 4, 0, 0, 0, 1));
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 4, 4, 0, 0, 0, 1));
        // Single bad marker in LOCKED, then clean, then clr_err
        vecs.push_back(mk(1, 5, 0, 4'h4, 0, 1, 4, 4, 1, 1, 1, 1));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 1, 4, 4, 0, 1, 1, 1));
        vecs.push_back(mk(1, 5, 0, 4'h8, 1, 1, 4, 4, 0, 0, 0, 1));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 4, 4, 4, 0, 0, 0, 1));
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 4, 4, 0, 0, 0, 1));
        // Missing strobe then late (early) strobe: two error cycles -> HUNT
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 7, 4, 4, 0, 0, 0, 1));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 1, 4, 4, 1, 1, 0, 1));
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 2, 0, 0, 2, 0, 0));
        // Early strobe in CHECK at per_cnt=3
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 3, 1, 0, 2, 0, 0));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 3, 3, 1, 0, 2, 0, 0));
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 2, 0, 0, 3, 0, 0));
        // clr_err coinciding with an error cycle leaves err_cnt=1
        vecs.push_back(mk(1, 5, 1, 4'h8, 0, 1, 3, 1, 0, 3, 0, 0));
        vecs.push_back(mk(1, 5, 1, 4'h8, 1, 1, 2, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 5, 0, 4'h8, 0, 1, 2, 0, 0, 1, 0, 0));
        // Drop to IDLE (err kept), then zero delay relock
        vecs.push_back(mk(0, 0, 0, 4'h8, 0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'h8, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'h8, 0, 1, 2, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'h8, 0, 1, 3, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'h8, 0, 7, 3, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'h8, 0, 1, 3, 2, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'h8, 0, 7, 3, 2, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'h8, 0, 1, 3, 3, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'h8, 0, 7, 3, 3, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 4'h8, 0, 1, 4, 4, 0, 1, 0, 1));
        // rx_online falls while LOCKED
        vecs.push_back(mk(0, 0, 0, 4'h8, 0, 1, 0, 0, 0, 1, 0, 0));

        rst_wr = 1'b1;
        rx_online = 1'b0; dly = '0; stb = 1'b0; mrk = 4'h8; clr = 1'b0;
        rx_online2 = 1'b0; dly2 = '0; stb2 = 1'b0; mrk2 = 4'h8; clr2 = 1'b0;
        repeat (3) @(posedge clk_wr);
        #1;
        check("reset_status", status, 32'h0);
        check("reset_od", {31'b0, od}, 32'h0);
        check("reset_status_sat", status2, 32'h0);
        rst_wr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            rx_online = vecs[i].online;
            dly       = vecs[i].dly;
            stb       = vecs[i].stb;
            mrk       = vecs[i].mrk;
            clr       = vecs[i].clr;
            repeat (vecs[i].n) @(posedge clk_wr);
            #1;
            check($sformatf("vec%0d_status", i), status,
                  exp_status(vecs[i].st, vecs[i].od, vecs[i].sticky, vecs[i].good,
                             vecs[i].loss, vecs[i].err));
            check($sformatf("vec%0d_od", i), {31'b0, od}, {31'b0, vecs[i].od});
        end

        // Saturation: bad marker every clock, strobe always high; each LOCKED stint
        // produces 15 error cycles, each HUNT clock relocks, so 74800 clocks > 70000 errors.
        rx_online2 = 1'b1; dly2 = 16'd0; stb2 = 1'b1; mrk2 = 4'h0;
        begin
            int budget;
            budget = 20;
            while (!od2 && budget > 0) begin
                @(posedge clk_wr);
                #1;
                budget--;
            end
        end
        check("sat_first_lock", {31'b0, od2}, 32'h1);
        repeat (74800) @(posedge clk_wr);
        #1;
        check("sat_err_cnt", {16'h0, status2[31:16]}, 32'h0000_FFFF);
        check("sat_sticky", {31'b0, status2[4]}, 32'h1);
        repeat (5) @(posedge clk_wr);
        #1;
        check("sat_err_hold", {16'h0, status2[31:16]}, 32'h0000_FFFF);
        rx_online2 = 1'b0;
        @(posedge clk_wr);
        #1;
        check("sat_idle_status", status2, exp_status(3'd0, 1'b0, 1'b1, 4'd0, 4'd0, 16'hFFFF));
        clr2 = 1'b1;
        @(posedge clk_wr);
        #1;
        clr2 = 1'b0;
        check("sat_clr_status", status2, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
